wb_host_master: RTL and testbench
=================================

Name: wb_host_master

Overview:
- Wishbone classic single-beat bus master: the initiator end of the enclave's wbs_* slave port.
- Accepts word-level read/write commands on a valid/ready command channel and runs one Wishbone cycle per command.
- Returns read data, or a timeout error, on a valid/ready response channel.
- Used as the host-side driver in system benches and as an on-chip sequencer that loads opcodes (OPCODE_ADDR 32'h30000000) and reads results (OUTPUT_ADDR 32'h10000000).

Parameters:
ADDR_WIDTH, 32, Wishbone address width
DATA_WIDTH, 32, Wishbone data width
SEL_WIDTH, 4, byte-select width (DATA_WIDTH/8)
TIMEOUT, 16, max cycles stb may stay asserted without ack before abort (>=1)
TIMEOUT_WIDTH, 5, counter width, must hold TIMEOUT

Ports:
wb_clk_i  in  1  clock; all logic rising-edge
wb_rst_i  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  master can accept command
cmd_we  in  1  1=write, 0=read
cmd_adr  in  ADDR_WIDTH  target address
cmd_dat  in  DATA_WIDTH  write data
cmd_sel  in  SEL_WIDTH  byte selects
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_dat  out  DATA_WIDTH  read data (0 for writes and errors)
rsp_err  out  1  1=timed out
wbm_cyc_o  out  1  bus cycle
wbm_stb_o  out  1  strobe
wbm_we_o  out  1  write enable
wbm_sel_o  out  SEL_WIDTH  byte selects
wbm_adr_o  out  ADDR_WIDTH  address
wbm_dat_o  out  DATA_WIDTH  write data
wbm_ack_i  in  1  slave acknowledge
wbm_dat_i  in  DATA_WIDTH  slave read data
busy  out  1  state != IDLE

Behaviour:
- Single clock wb_clk_i; reset wb_rst_i is synchronous and active-high. All outputs are registered.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_dat=0, rsp_err=0, wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0, busy=0, state=IDLE, counter=0.
- States:
  - IDLE: cmd_ready=1.
  - BUS: cyc=stb=1, cmd_ready=0.
  - RESP: rsp_valid=1, cmd_ready=0.
- IDLE -> BUS: on an edge with cmd_valid&&cmd_ready, register we/adr/dat/sel onto wbm_*; cyc/stb high from the next cycle; counter=0.
- Address and sel pass through unmodified; there is no alignment check.
- wbm_we_o/adr/sel/dat are stable for the whole BUS state. wbm_dat_o is driven on reads too (value ignored by the slave).
- BUS, ack sampled high at an edge:
  - Next cycle: cyc=stb=0, state=RESP, rsp_err=0.
  - rsp_dat = wbm_dat_i for reads, 0 for writes.
  - Minimum command-to-response latency is 2 cycles (accept edge, then ack edge).
- BUS, no ack: counter increments each edge. At the edge where counter==TIMEOUT-1 without ack, the cycle aborts: cyc=stb=0, RESP with rsp_err=1, rsp_dat=0. stb is therefore high for exactly TIMEOUT cycles.
- Ack on the same edge as the timeout condition: ack wins, so the response is normal and rsp_err=0.
- RESP: rsp_valid, rsp_dat and rsp_err hold until rsp_valid&&rsp_ready at an edge; then IDLE, with rsp_valid=0 and cmd_ready=1 next cycle. Maximum throughput is one command per 3 cycles.
- wbm_ack_i in IDLE or RESP is ignored, with no state or data change. Late acks arriving after a timeout are dropped.
- cmd_valid in BUS/RESP: not accepted; the command inputs may change freely until cmd_ready.
- Reset mid-operation (any state): outputs return to reset values at the next edge and cyc drops immediately. The in-flight command is lost and no response is produced.
- One outstanding transaction only. There are no bursts and no err/rty inputs.

Test Plan:
1. Write cmd adr=32'h30000000 dat=32'h00000001 sel=4'hF; slave acks on 2nd stb cycle -> cyc/stb high 2 cycles with we=1; rsp_valid next cycle with rsp_err=0, rsp_dat=0.
2. Read cmd adr=32'h10000000; slave acks with wbm_dat_i=32'hDEADBEEF on 1st stb cycle -> rsp_dat=32'hDEADBEEF, rsp_err=0, 2-cycle latency from accept to rsp_valid.
3. TIMEOUT=16, read with no ack -> stb high exactly 16 cycles, then rsp_valid with rsp_err=1, rsp_dat=0. A second bench run with ack on cycle 16 -> rsp_err=0.
4. Backpressure: hold rsp_ready=0 for 5 cycles after a read of 32'h12345678 -> rsp held stable, cmd_ready=0 throughout, spurious ack ignored; rsp_ready=1 -> IDLE and cmd_ready=1 next cycle.
5. Assert wb_rst_i for 1 cycle in the 3rd BUS cycle -> cyc/stb=0 at the next edge, no rsp_valid; a new write then completes normally.
6. Back-to-back: 4 writes to consecutive addresses 32'h30000000..3000000C with rsp_ready tied 1 and immediate ack -> 4 responses, one every 3 cycles, in order, no dropped commands.

Source files
------------

// File: rtl/wb_host_master.sv
// Wishbone classic single-beat master: one bus cycle per command, response returned on a valid/ready channel.
// Latency: 2 cycles minimum from command accept to rsp_valid; abort after TIMEOUT strobe cycles without ack.
// Backpressure: cmd_ready is low while a transaction is in flight; the response holds until rsp_ready.
module wb_host_master #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SEL_WIDTH     = 4,
    parameter int TIMEOUT       = 16,
    parameter int TIMEOUT_WIDTH = 5
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_adr,
    input  logic [DATA_WIDTH-1:0] cmd_dat,
    input  logic [SEL_WIDTH-1:0]  cmd_sel,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_dat,
    output logic                  rsp_err,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [SEL_WIDTH-1:0]  wbm_sel_o,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [DATA_WIDTH-1:0] wbm_dat_o,
    input  logic                  wbm_ack_i,
    input  logic [DATA_WIDTH-1:0] wbm_dat_i,
    output logic                  busy
);

    // One-hot so every status output is a direct decode of a single state flop.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        BUS  = 3'b010,
        RESP = 3'b100
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
    logic                     timeout_hit;

    assign timeout_hit = (tmo_cnt == TIMEOUT_WIDTH'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid)                 state_nxt = BUS;
            BUS:     if (wbm_ack_i || timeout_hit)  state_nxt = RESP;
            RESP:    if (rsp_ready)                 state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        wbm_cyc_o = (state == BUS);
        wbm_stb_o = (state == BUS);
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    // Bus request fields are captured once at accept and stay frozen for the whole cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                wbm_we_o  <= cmd_we;
                wbm_sel_o <= cmd_sel;
                wbm_adr_o <= cmd_adr;
                wbm_dat_o <= cmd_dat;
                tmo_cnt   <= '0;
            end
            if (state == BUS) begin
                // An ack on the timeout edge still completes normally.
                if (wbm_ack_i) begin
                    rsp_dat <= wbm_we_o ? '0 : wbm_dat_i;
                    rsp_err <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_dat <= '0;
                    rsp_err <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master: a scripted slave, a response scoreboard and per-step checks.
module tb_wb_host_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 16;
    localparam int TW  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_dat;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [SW-1:0] wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o, wbm_dat_i;
    logic          busy;

    always #5 clk = ~clk;

    wb_host_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT(TMO), .TIMEOUT_WIDTH(TW)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy(busy)
    );

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   n_rsp   = 0;
    int   cyc_cnt = 0;
    int   ack_on  = 0;        // ack on the Nth strobe cycle; 0 = never
    logic spurious = 1'b0;    // ack driven while no strobe is present

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave: decides ack for the coming edge from the current strobe run length.
    initial begin
        int cnt;
        cnt = 0;
        wbm_ack_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (wbm_stb_o) begin
                cnt++;
                wbm_ack_i = (ack_on != 0) && (cnt == ack_on);
            end else begin
                cnt = 0;
                wbm_ack_i = spurious;
            end
        end
    end

    // Response monitor: every handshake pops the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                n_cmp++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("FAIL rsp_unexpected observed dat=%h err=%b expected no response", rsp_dat, rsp_err);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rsp_dat", rsp_dat, e.dat);
                    check("rsp_err", rsp_err, e.err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until accepted; returns the accept-edge cycle number.
    task automatic issue(input string tag, input logic we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input logic [SW-1:0] sel, output int acc);
        logic ok;
        ok = 1'b0;
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_accepted"}, ok, 1'b1);
        @(posedge clk);
        acc = cyc_cnt;
        #1;
        cmd_valid = 1'b0;
        cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
    endtask

    // Full transaction: push expectation, issue, watch the bus cycle, check its shape and latency.
    task automatic xact(input string tag, input logic we, input logic [AW-1:0] adr,
                        input logic [DW-1:0] dat, input logic [SW-1:0] sel, input int ack,
                        input logic [DW-1:0] exp_dat, input logic exp_err,
                        input int exp_stb, input int exp_lat, output int acc);
        int   stb_n, lat;
        logic stable, seen;
        ack_on = ack;
        sb.push_back('{dat: exp_dat, err: exp_err});
        issue(tag, we, adr, dat, sel, acc);
        stb_n = 0; lat = 0; stable = 1'b1; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (wbm_stb_o) begin
                stb_n++;
                stable &= wbm_cyc_o && (wbm_we_o === we) && (wbm_adr_o === adr) &&
                          (wbm_dat_o === dat) && (wbm_sel_o === sel) && !cmd_ready && busy;
            end
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_rsp_seen"}, seen, 1'b1);
        check({tag, "_bus_stable"}, stable, 1'b1);
        check({tag, "_stb_cycles"}, stb_n, exp_stb);
        check({tag, "_latency"}, lat, exp_lat);
        tick();
    endtask

    initial begin
        int acc, acc_prev, seen_v;
        logic [AW-1:0] a;
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b1; wbm_dat_i = '0;
        tick();
        tick();
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_cyc_stb", {wbm_cyc_o, wbm_stb_o, busy}, 3'b000);
        check("rst_bus_fields", {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, '0);
        check("rst_rsp_fields", {rsp_err, rsp_dat}, '0);
        tick();
        rst = 1'b0;
        tick();

        // Write, ack on second strobe; the slave's read bus carries junk that must not leak.
        wbm_dat_i = 32'hBAD0BAD0;
        xact("wr_opcode", 1'b1, 32'h30000000, 32'h00000001, 4'hF, 2, 32'h0, 1'b0, 2, 3, acc);

        // Read, ack on first strobe: minimum latency.
        wbm_dat_i = 32'hDEADBEEF;
        xact("rd_output", 1'b0, 32'h10000000, 32'h0, 4'hF, 1, 32'hDEADBEEF, 1'b0, 1, 2, acc);

        // Timeout with no ack, then ack landing exactly on the timeout edge.
        wbm_dat_i = 32'h55AA55AA;
        xact("rd_timeout", 1'b0, 32'h10000004, 32'h0, 4'hF, 0, 32'h0, 1'b1, TMO, TMO + 1, acc);
        wbm_dat_i = 32'hCAFEF00D;
        xact("rd_ack_at_tmo", 1'b0, 32'h10000008, 32'h0, 4'h3, TMO, 32'hCAFEF00D, 1'b0, TMO, TMO + 1, acc);

        // Backpressure with a spurious ack while the response is pending.
        rsp_ready = 1'b0;
        wbm_dat_i = 32'h12345678;
        ack_on = 1;
        sb.push_back('{dat: 32'h12345678, err: 1'b0});
        issue("rd_bp", 1'b0, 32'h10000010, 32'h0, 4'hF, acc);
        tick();
        spurious = 1'b1;
        wbm_dat_i = 32'h0BADF00D;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {rsp_valid, rsp_err, rsp_dat, cmd_ready, wbm_stb_o},
                  {1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0});
            tick();
        end
        spurious = 1'b0;
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_release", {rsp_valid, cmd_ready, busy}, 3'b010);
        tick();

        // Reset during the third bus cycle: transaction dropped, no response.
        ack_on = 0;
        issue("rst_mid", 1'b1, 32'h30000020, 32'hA5A5A5A5, 4'hF, acc);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_stb_before", wbm_stb_o, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_after", {wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready, busy}, 5'b00010);
        check("rst_mid_adr", wbm_adr_o, 32'h0);
        seen_v = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) seen_v++;
        end
        check("rst_mid_no_rsp", seen_v, 0);
        tick();
        wbm_dat_i = 32'hBAD0BAD0;
        xact("wr_after_rst", 1'b1, 32'h30000000, 32'h00000002, 4'hF, 1, 32'h0, 1'b0, 1, 2, acc);

        // Back-to-back writes: one accepted every three cycles.
        acc_prev = 0;
        for (int k = 0; k < 4; k++) begin
            a = 32'h30000000 + AW'(4 * k);
            xact("wr_b2b", 1'b1, a, 32'h100 + DW'(k), 4'hF, 1, 32'h0, 1'b0, 1, 2, acc);
            if (k > 0) check("b2b_spacing", acc - acc_prev, 3);
            acc_prev = acc;
        end

        repeat (4) tick();
        check("sb_drained", sb.size(), 0);
        check("rsp_count", n_rsp, 10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
